// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store initiator between EX/MEM and the data memory
module lsu_mem_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 256,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  // one extra bit so MEM_WORDS == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);
  logic [1:0] state;
  logic       op_we;
  logic [2:0] cnt;
  logic       fault;
  always_comb fault = {1'b0, req_addr} >= LIMIT;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign mem_wr    = state == WRITE && op_we;
  assign mem_rd    = state == READ && !op_we;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      op_we     <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            op_we     <= req_we;
            cnt       <= 3'(RD_LAT);
            rsp_rdata <= '0;
            rsp_err   <= fault;
            state     <= fault ? RESP : req_we ? WRITE : READ;
          end
        WRITE: state <= RESP;
        READ:
          if (cnt == 3'd0) begin
            rsp_rdata <= mem_rdata;
            state     <= RESP;
          end else
            cnt <= cnt - 3'd1;
        RESP:    state <= rsp_ready ? IDLE : RESP;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized load/store traffic against an array-based reference of memory contents and timing
module tb_lsu_mem_ctrl;
  localparam int RD_LAT = 1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_rdata;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  int checks = 0, errors = 0;

  lsu_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(256), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at a negedge with the controller back in IDLE
  task automatic xact(input logic we, input logic [15:0] a, input logic [15:0] d, input int stall);
    logic err;
    logic [15:0] rd;
    int lat, nwr, nrd, exp_lat;
    err = a >= 16'd256;
    rd = (we || err) ? 16'h0 : ref_mem[a[7:0]];
    if (we && !err) ref_mem[a[7:0]] = d;
    exp_lat = err ? 1 : we ? 2 : RD_LAT + 2;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
    chk("idle_ready", req_ready, 1);
    @(posedge clk); #1;
    req_we = ~we; req_addr = 16'($urandom); req_wdata = 16'($urandom);
    lat = 0; nwr = 0; nrd = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_wr) begin nwr++; chk("wr_addr", mem_addr, a); chk("wr_data", mem_wdata, d); end
      if (mem_rd) begin nrd++; chk("rd_addr", mem_addr, a); end
      chk("strobe_excl", mem_rd & mem_wr, 0);
      chk("busy_ready", req_ready, 0);
    end while (!rsp_valid && lat < 20);
    chk("latency", lat, exp_lat);
    chk("rsp_rdata", rsp_rdata, rd);
    chk("rsp_err", rsp_err, err);
    chk("wr_pulses", nwr, (we && !err) ? 1 : 0);
    chk("rd_pulses", nrd, (!we && !err) ? RD_LAT + 1 : 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", rsp_err, err);
      chk("hold_ready", req_ready, 0);
      chk("hold_strobe", mem_rd | mem_wr, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", rsp_valid, 0);
    chk("done_ready", req_ready, 1);
    rsp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"}, mem_rd, 0);
    chk({tag, "_wr"}, mem_wr, 0);
    chk({tag, "_valid"}, rsp_valid, 0);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
  endtask

  initial begin
    logic [15:0] v, old;
    int kind;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    #3;
    chk_reset("por");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    xact(1'b1, 16'h0004, 16'h1234, 0);
    xact(1'b0, 16'h0004, 16'h0000, 0);
    xact(1'b1, 16'h0050, 16'hBEEF, 0);
    xact(1'b0, 16'h0050, 16'h0000, 5);
    xact(1'b1, 16'h0100, 16'h5555, 0);
    xact(1'b0, 16'hFFFF, 16'h0000, 2);
    xact(1'b0, 16'h00FF, 16'h0000, 0);
    xact(1'b1, 16'h00FF, 16'hA5A5, 1);
    xact(1'b0, 16'h00FF, 16'h0000, 0);
    // asynchronous reset in the middle of a load
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rd_active", mem_rd, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_rd");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    // asynchronous reset while the store strobe is high
    old = ref_mem[8'h20];
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = ~old;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_wr_active", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_wr");
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_wr_norsp", rsp_valid, 0);
    end
    chk("rst_wr_mem", mem[8'h20], old);
    xact(1'b0, 16'h0020, 16'h0000, 0);
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 4);
      v = (kind == 0) ? 16'($urandom) : (kind == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 255));
      xact(1'($urandom), v, 16'($urandom), $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
